imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_loader_byte_pair_assembler.sv | 31 +++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: ISA widths, reset vector
// and the loader state encoding.
package imem_loader_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned IMEM_ADDR_W = 20;
    localparam logic [IMEM_ADDR_W-1:0] RESET_PC = 20'h00020;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR_LO = 4'd1,
        ST_HDR_HI = 4'd2,
        ST_DAT_LO = 4'd3,
        ST_DAT_HI = 4'd4,
        ST_WRITE  = 4'd5,
        ST_CK_LO  = 4'd6,
        ST_CK_HI  = 4'd7,
        ST_FIN    = 4'd8
    } ld_state_e;

    // States in which the loader offers in_ready to the byte source.
    function automatic logic is_rx_state(input ld_state_e s);
        case (s)
            ST_HDR_LO, ST_HDR_HI, ST_DAT_LO, ST_DAT_HI, ST_CK_LO, ST_CK_HI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // States whose byte is the high half of a little-endian pair.
    function automatic logic is_hi_state(input ld_state_e s);
        case (s)
            ST_HDR_HI, ST_DAT_HI, ST_CK_HI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Little-endian byte pair capture: holds the low byte and presents the full word
// together with word_valid during the high-byte transfer.
module byte_pair_assembler
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               xfer,
    input  logic               hi_sel,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [7:0] lo_r;

    // Low-byte capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_r <= 8'h00;
        end else if (xfer && !hi_sel) begin
            lo_r <= byte_in;
        end else begin
            lo_r <= lo_r;
        end
    end

    assign word       = {byte_in, lo_r};
    assign word_valid = xfer && hi_sel;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header count, then N little-endian words written to memory,
// fetch released on success. Define IMEM_LOADER_CHKSUM_EN for a trailing XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned       DATA_W    = INSTR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h00000,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              memWR,
    output logic [ADDR_W-1:0] addWR,
    output logic [DATA_W-1:0] dataWR,
    output logic              fetch_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_written
);

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam ld_state_e ST_AFTER_DATA = ST_CK_LO;
`else
    localparam ld_state_e ST_AFTER_DATA = ST_FIN;
`endif

    ld_state_e           state_r, next_state_s;
    logic                in_ready_r, mem_wr_r, fetch_en_r, busy_r, done_r;
    logic [ADDR_W-1:0]   ptr_r, add_wr_r;
    logic [DATA_W-1:0]   data_wr_r;
    logic [CNT_W-1:0]    count_r, ww_r, ww_inc_s;
    logic [INSTR_W-1:0]  word_s;
    logic                word_valid_s, xfer_s, launch_s, ck_bad_s;

    assign xfer_s   = in_valid && in_ready_r;
    assign launch_s = (state_r == ST_IDLE) && start;
    assign ww_inc_s = ww_r + CNT_W'(1'b1);

    byte_pair_assembler u_bpa (
        .clk       (clk),
        .rst       (rst),
        .xfer      (xfer_s),
        .hi_sel    (is_hi_state(state_r)),
        .byte_in   (in_data),
        .word      (word_s),
        .word_valid(word_valid_s)
    );

`ifdef IMEM_LOADER_CHKSUM_EN
    logic [DATA_W-1:0] ck_acc_r;
    logic              err_r;

    assign ck_bad_s = (state_r == ST_CK_HI) && word_valid_s && (word_s != ck_acc_r);

    // Running XOR of committed words and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_acc_r <= {DATA_W{1'b0}};
            err_r    <= 1'b0;
        end else if (launch_s) begin
            ck_acc_r <= {DATA_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            ck_acc_r <= ((state_r == ST_DAT_HI) && word_valid_s) ? (ck_acc_r ^ word_s) : ck_acc_r;
            err_r    <= err_r | ck_bad_s;
        end
    end

    assign err = err_r;
`else
    assign ck_bad_s = 1'b0;
    assign err      = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = start ? ST_HDR_LO : ST_IDLE;
            ST_HDR_LO: next_state_s = xfer_s ? ST_HDR_HI : ST_HDR_LO;
            ST_HDR_HI: begin
                if (word_valid_s) begin
                    next_state_s = (word_s == 16'h0000) ? ST_AFTER_DATA : ST_DAT_LO;
                end else begin
                    next_state_s = ST_HDR_HI;
                end
            end
            ST_DAT_LO: next_state_s = xfer_s ? ST_DAT_HI : ST_DAT_LO;
            ST_DAT_HI: next_state_s = xfer_s ? ST_WRITE : ST_DAT_HI;
            ST_WRITE:  next_state_s = (ww_inc_s == count_r) ? ST_AFTER_DATA : ST_DAT_LO;
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CK_LO:  next_state_s = xfer_s ? ST_CK_HI : ST_CK_LO;
            ST_CK_HI:  next_state_s = xfer_s ? ST_FIN : ST_CK_HI;
`endif
            ST_FIN:    next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake and session status; done/busy/fetch_en are set on the edge entering FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fetch_en_r <= 1'b0;
        end else begin
            in_ready_r <= is_rx_state(next_state_s);
            done_r     <= (next_state_s == ST_FIN) && (state_r != ST_FIN);
            if (launch_s) begin
                busy_r     <= 1'b1;
                fetch_en_r <= 1'b0;
            end else if ((next_state_s == ST_FIN) && (state_r != ST_FIN)) begin
                busy_r     <= 1'b0;
                fetch_en_r <= !ck_bad_s;
            end else begin
                busy_r     <= busy_r;
                fetch_en_r <= fetch_en_r;
            end
        end
    end

    // Header count capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_HDR_HI) && word_valid_s) begin
            count_r <= word_s;
        end else begin
            count_r <= count_r;
        end
    end

    // Memory write port, address pointer and committed-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_r  <= 1'b0;
            add_wr_r  <= {ADDR_W{1'b0}};
            data_wr_r <= {DATA_W{1'b0}};
            ptr_r     <= {ADDR_W{1'b0}};
            ww_r      <= {CNT_W{1'b0}};
        end else if (launch_s) begin
            mem_wr_r  <= 1'b0;
            ptr_r     <= BASE_ADDR;
            ww_r      <= {CNT_W{1'b0}};
        end else if ((state_r == ST_DAT_HI) && word_valid_s) begin
            mem_wr_r  <= 1'b1;
            add_wr_r  <= ptr_r;
            data_wr_r <= word_s;
        end else if (state_r == ST_WRITE) begin
            mem_wr_r  <= 1'b0;
            ptr_r     <= ptr_r + ADDR_W'(1'b1);
            ww_r      <= ww_inc_s;
        end else begin
            mem_wr_r  <= 1'b0;
        end
    end

    assign in_ready      = in_ready_r;
    assign memWR         = mem_wr_r;
    assign addWR         = add_wr_r;
    assign dataWR        = data_wr_r;
    assign fetch_en      = fetch_en_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = ww_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 0xFFFFF) share one byte stream.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;

    logic        a_in_ready, a_memwr, a_fetch_en, a_busy, a_done, a_err;
    logic [19:0] a_addwr;
    logic [15:0] a_datawr, a_ww;
    logic        b_in_ready, b_memwr, b_fetch_en, b_busy, b_done, b_err;
    logic [19:0] b_addwr;
    logic [15:0] b_datawr, b_ww;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rdy_in_write = 0;
    logic [35:0] wr_a[$];
    logic [35:0] wr_b[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    imem_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .memWR(a_memwr), .addWR(a_addwr), .dataWR(a_datawr),
        .fetch_en(a_fetch_en), .busy(a_busy), .done(a_done), .err(a_err), .words_written(a_ww)
    );

    imem_loader #(.BASE_ADDR(20'hFFFFF)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .memWR(b_memwr), .addWR(b_addwr), .dataWR(b_datawr),
        .fetch_en(b_fetch_en), .busy(b_busy), .done(b_done), .err(b_err), .words_written(b_ww)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input bit use_b, input int i,
                            input logic [19:0] ea, input logic [15:0] ed);
        logic [35:0] e;
        if (use_b) e = (i < wr_b.size()) ? wr_b[i] : 36'hF_FFFF_FFFF;
        else       e = (i < wr_a.size()) ? wr_a[i] : 36'hF_FFFF_FFFF;
        check_val({tag, " addr"}, {12'h000, e[35:16]}, {12'h000, ea});
        check_val({tag, " data"}, {16'h0000, e[15:0]}, {16'h0000, ed});
    endtask

    // Write-port and handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_memwr) wr_a.push_back({a_addwr, a_datawr});
        if (b_memwr) wr_b.push_back({b_addwr, b_datawr});
        if (a_done) done_cnt++;
        if (a_memwr && a_in_ready) rdy_in_write++;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!a_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_val("in_ready timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pulses start at a falling edge; optionally re-pulses start before byte poke_at.
    task automatic load(input bit gaps, input int poke_at);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy after start", a_busy, 1'b1);
        check_val("fetch_en drops on start", a_fetch_en, 1'b0);
        check_val("err cleared on start", a_err, 1'b0);
        check_val("ww cleared on start", a_ww, 16'd0);
        foreach (img[i]) begin
            if (i == poke_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(img[i], gaps);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!a_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("done seen", a_done, 1'b1);
        @(negedge clk);
    endtask

    task automatic set_two_word_img();
        img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef IMEM_LOADER_CHKSUM_EN
        img.push_back(8'h4C);
        img.push_back(8'h44);
`endif
    endtask

    task automatic check_two_word_result(input string tag, input int done_before);
        check_val({tag, " write count"}, wr_a.size(), 2);
        check_wr({tag, " w0"}, 1'b0, 0, 20'h00000, 16'h1234);
        check_wr({tag, " w1"}, 1'b0, 1, 20'h00001, 16'h5678);
        check_wr({tag, " wrap w0"}, 1'b1, 0, 20'hFFFFF, 16'h1234);
        check_wr({tag, " wrap w1"}, 1'b1, 1, 20'h00000, 16'h5678);
        check_val({tag, " fetch_en"}, a_fetch_en, 1'b1);
        check_val({tag, " words_written"}, a_ww, 16'd2);
        check_val({tag, " busy idle"}, a_busy, 1'b0);
        check_val({tag, " err"}, a_err, 1'b0);
        check_val({tag, " done pulses"}, done_cnt - done_before, 1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst in_ready", a_in_ready, 1'b0);
        check_val("rst memWR", a_memwr, 1'b0);
        check_val("rst addWR", a_addwr, 20'h0);
        check_val("rst dataWR", a_datawr, 16'h0);
        check_val("rst fetch_en", a_fetch_en, 1'b0);
        check_val("rst busy", a_busy, 1'b0);
        check_val("rst done", a_done, 1'b0);
        check_val("rst err", a_err, 1'b0);
        check_val("rst words_written", a_ww, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word image, in_valid always high; second instance checks address wrap.
        set_two_word_img();
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b0, -1);
        wait_done();
        check_two_word_result("basic", d0);

        // Same image with gaps, junk data between bytes and a start pulse while busy.
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b1, 3);
        wait_done();
        check_two_word_result("gapped", d0);
        check_val("in_ready low during WRITE", rdy_in_write, 0);

        // Reset mid-session after three data bytes.
        img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78};
        wr_a.delete(); wr_b.delete();
        load(1'b0, -1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst memWR", a_memwr, 1'b0);
        check_val("midrst busy", a_busy, 1'b0);
        check_val("midrst fetch_en", a_fetch_en, 1'b0);
        check_val("midrst words_written", a_ww, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h99;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check_val("midrst no writes after", wr_a.size(), 1);
        check_val("midrst stays idle", a_in_ready, 1'b0);
        set_two_word_img();
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b0, -1);
        wait_done();
        check_two_word_result("reload", d0);

        // Empty image: no writes, done right after the header.
`ifdef IMEM_LOADER_CHKSUM_EN
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
        img = '{8'h00, 8'h00};
`endif
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b0, -1);
`ifndef IMEM_LOADER_CHKSUM_EN
        check_val("empty done after hdr", a_done, 1'b1);
`endif
        wait_done();
        check_val("empty write count", wr_a.size(), 0);
        check_val("empty fetch_en", a_fetch_en, 1'b1);
        check_val("empty words_written", a_ww, 16'd0);
        check_val("empty done pulses", done_cnt - d0, 1);

`ifdef IMEM_LOADER_CHKSUM_EN
        // Bad checksum: error, fetch held off, done still pulses; next start clears err.
        img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00};
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b0, -1);
        wait_done();
        check_val("badck err", a_err, 1'b1);
        check_val("badck fetch_en", a_fetch_en, 1'b0);
        check_val("badck done pulses", done_cnt - d0, 1);
        check_val("badck writes", wr_a.size(), 2);
        set_two_word_img();
        wr_a.delete(); wr_b.delete(); d0 = done_cnt;
        load(1'b0, -1);
        wait_done();
        check_two_word_result("goodck", d0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
